// File: rtl/constants_pkg.sv
// Machine-wide sizing constants shared by the datapath and writeback logic.
package constants_pkg;

    localparam int ARCH_LEN     = 32;
    localparam int REG_FILE_LEN = 32;
    localparam int REG_ADDR_W   = $clog2(REG_FILE_LEN);

endpackage : constants_pkg

// File: rtl/instruction_pkg.sv
// Types shared by the execution and writeback stages.
package instruction_pkg;

    import constants_pkg::*;

    // One completed result waiting for the register file write port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [ARCH_LEN-1:0]   data;
    } wb_entry_t;

    // Result producers feeding the writeback arbiter.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    // One-hot register mask for a destination index.
    function automatic logic [REG_FILE_LEN-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [REG_FILE_LEN-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : instruction_pkg

// File: rtl/wb_fifo.sv
// Small circular buffer of writeback entries. DEPTH must be a power of two
// (>= 2) so the read/write pointers wrap naturally. Every slot's destination
// and a per-slot occupancy flag are exported so the owner can build a
// pending-register mask without waiting for entries to reach the head.
module wb_fifo
    import constants_pkg::*;
    import instruction_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  wb_entry_t             entry_i,
    input  logic                  pop_i,
    output wb_entry_t             head_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [REG_ADDR_W-1:0] slot_dst_o [DEPTH],
    output logic [DEPTH-1:0]      slot_valid_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    // Guard against overflow/underflow even if the owner misbehaves.
    assign push_ok = push_i && (count_q != DEPTH_C);
    assign pop_ok  = pop_i  && (count_q != '0);

    // Storage, wrapping pointers and occupancy count; push+pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] offset;
        assign offset          = PTR_W'(g) - rd_ptr_q;
        assign slot_valid_o[g] = ({1'b0, offset} < count_q);
        assign slot_dst_o[g]   = mem_q[g].dst;
    end

endmodule : wb_fifo

// File: rtl/writeback_arbiter.sv
// Merges ALU and memory results onto the single register file write port.
// Each source has its own small buffer; a round-robin arbiter picks one head
// per cycle and loads it into registered write-port outputs. Handshake: a
// transfer happens on a rising edge where valid && ready; ready comes only
// from the registered buffer count (a same-cycle pop never raises it), and the
// producer must hold valid/dst/data stable while ready is low. Writes to x0
// are accepted and dropped. pending_mask lists every register with a write
// still buffered or on the port, so decode can stall on hazards.
module writeback_arbiter
    import constants_pkg::*;
    import instruction_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_ADDR_W-1:0]   alu_dst,
    input  logic [ARCH_LEN-1:0]     alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_ADDR_W-1:0]   mem_dst,
    input  logic [ARCH_LEN-1:0]     mem_data,
    output logic [REG_ADDR_W-1:0]   dst_reg,
    output logic [ARCH_LEN-1:0]     dst_reg_data,
    output logic                    reg_write_enable,
    output logic [REG_FILE_LEN-1:0] pending_mask
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Buffer interfaces
    wb_entry_t             alu_entry;
    wb_entry_t             mem_entry;
    wb_entry_t             alu_head;
    wb_entry_t             mem_head;
    logic                  alu_push;
    logic                  mem_push;
    logic [CNT_W-1:0]      alu_count;
    logic [CNT_W-1:0]      mem_count;
    logic                  alu_full;
    logic                  mem_full;
    logic                  alu_empty;
    logic                  mem_empty;
    logic [REG_ADDR_W-1:0] alu_slot_dst [FIFO_DEPTH];
    logic [REG_ADDR_W-1:0] mem_slot_dst [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] alu_slot_valid;
    logic [FIFO_DEPTH-1:0] mem_slot_valid;

    // Arbitration and write-port state
    logic                  grant_alu;
    logic                  grant_mem;
    wb_src_e               last_grant_q;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [ARCH_LEN-1:0]   data_q;
    logic [REG_FILE_LEN-1:0] pending_c;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign alu_ready = (alu_count < DEPTH_C);
    assign mem_ready = (mem_count < DEPTH_C);

    // x0 writes complete the handshake but never enter a buffer.
    assign alu_push  = alu_valid && alu_ready && (alu_dst != '0);
    assign mem_push  = mem_valid && mem_ready && (mem_dst != '0);
    assign alu_entry = '{dst: alu_dst, data: alu_data};
    assign mem_entry = '{dst: mem_dst, data: mem_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (alu_push),
        .entry_i      (alu_entry),
        .pop_i        (grant_alu),
        .head_o       (alu_head),
        .count_o      (alu_count),
        .full_o       (alu_full),
        .empty_o      (alu_empty),
        .slot_dst_o   (alu_slot_dst),
        .slot_valid_o (alu_slot_valid)
    );

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_mem_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (mem_push),
        .entry_i      (mem_entry),
        .pop_i        (grant_mem),
        .head_o       (mem_head),
        .count_o      (mem_count),
        .full_o       (mem_full),
        .empty_o      (mem_empty),
        .slot_dst_o   (mem_slot_dst),
        .slot_valid_o (mem_slot_valid)
    );

    // Round-robin pick: a lone non-empty buffer wins; on contention the source not granted last wins.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!alu_empty && (mem_empty || (last_grant_q == WB_SRC_MEM))) begin
            grant_alu = 1'b1;
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
        end
    end

    // Write-port registers and grant history; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            dst_q        <= '0;
            data_q       <= '0;
            last_grant_q <= WB_SRC_MEM;
        end else begin
            we_q <= grant_alu || grant_mem;
            if (grant_alu) begin
                dst_q        <= alu_head.dst;
                data_q       <= alu_head.data;
                last_grant_q <= WB_SRC_ALU;
            end else if (grant_mem) begin
                dst_q        <= mem_head.dst;
                data_q       <= mem_head.data;
                last_grant_q <= WB_SRC_MEM;
            end
        end
    end

    assign reg_write_enable = we_q;
    assign dst_reg          = dst_q;
    assign dst_reg_data     = data_q;

    // Pending mask: OR of every live buffered destination plus the write on the port.
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_slot_valid[i]) begin
                pending_c = pending_c | reg_onehot(alu_slot_dst[i]);
            end
            if (mem_slot_valid[i]) begin
                pending_c = pending_c | reg_onehot(mem_slot_dst[i]);
            end
        end
        if (we_q) begin
            pending_c = pending_c | reg_onehot(dst_q);
        end
        pending_c[0] = 1'b0;
    end

    assign pending_mask = pending_c;

    // Structural sanity checks; ignored by synthesis.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        !(grant_alu && grant_mem));
    a_alu_full_count: assert property (@(posedge clk) disable iff (rst)
        alu_full == (alu_count == DEPTH_C));
    a_mem_full_count: assert property (@(posedge clk) disable iff (rst)
        mem_full == (mem_count == DEPTH_C));
    a_no_x0_write: assert property (@(posedge clk) disable iff (rst)
        !(we_q && (dst_q == '0)));

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: reset checks, a hand-derived vector table,
// backpressure and mid-stream reset sequences, then random traffic checked
// against a queue-based behavioural model.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          rst_before;
        bit          av;
        logic [4:0]  ad;
        logic [31:0] aw;
        bit          mv;
        logic [4:0]  md;
        logic [31:0] mw;
        bit          e_we;
        logic [4:0]  e_dst;
        logic [31:0] e_data;
        logic [31:0] e_mask;
        bit          e_ar;
        bit          e_mr;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_dst, mem_dst, dst_reg;
    logic [31:0] alu_data, mem_data, dst_reg_data, pending_mask;
    logic        reg_write_enable;

    always #5 clk = ~clk;

    writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_dst          (alu_dst),
        .alu_data         (alu_data),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_dst          (mem_dst),
        .mem_data         (mem_data),
        .dst_reg          (dst_reg),
        .dst_reg_data     (dst_reg_data),
        .reg_write_enable (reg_write_enable),
        .pending_mask     (pending_mask)
    );

    // ---------------- scoreboard / model ----------------
    int   total = 0;
    int   bad   = 0;
    ent_t aq[$];
    ent_t mq[$];
    bit   last_mem;
    bit   m_we;
    logic [4:0]  m_dst;
    logic [31:0] m_data;
    bit   last_a_acc, last_m_acc;
    int   wcount[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (aq[i]) m[aq[i].dst] = 1'b1;
        foreach (mq[i]) m[mq[i].dst] = 1'b1;
        if (m_we) m[m_dst] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        aq.delete();
        mq.delete();
        last_mem = 1'b1;
        m_we     = 1'b0;
        m_dst    = '0;
        m_data   = '0;
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic tick();
        bit   a_acc, m_acc;
        ent_t e;
        a_acc = alu_valid && (aq.size() < DEPTH);
        m_acc = mem_valid && (mq.size() < DEPTH);
        @(posedge clk);
        m_we = 1'b0;
        e    = '0;
        if (aq.size() > 0 && (mq.size() == 0 || last_mem)) begin
            e = aq.pop_front(); m_we = 1'b1; last_mem = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front(); m_we = 1'b1; last_mem = 1'b1;
        end
        if (m_we) begin
            m_dst  = e.dst;
            m_data = e.data;
        end
        if (a_acc && alu_dst != 0) aq.push_back('{dst: alu_dst, data: alu_data});
        if (m_acc && mem_dst != 0) mq.push_back('{dst: mem_dst, data: mem_data});
        last_a_acc = a_acc;
        last_m_acc = m_acc;
        #1;
        chk("we", reg_write_enable, m_we);
        chk("dst_reg", dst_reg, m_dst);
        chk("dst_data", dst_reg_data, m_data);
        chk("pending_mask", pending_mask, model_mask());
        chk("alu_ready", alu_ready, aq.size() < DEPTH);
        chk("mem_ready", mem_ready, mq.size() < DEPTH);
        if (reg_write_enable === 1'b1) wcount[dst_reg]++;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dst = '0; mem_data = '0;
    endtask

    // Called at posedge+1: assert reset across one edge and release away from it.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- test body ----------------
    vec_t vt[11];
    int   ai, mi, drop_at;
    ent_t a_cur, m_cur;

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        foreach (wcount[i]) wcount[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", reg_write_enable, 1'b0);
        chk("rst_dst", dst_reg, 5'd0);
        chk("rst_data", dst_reg_data, 32'h0);
        chk("rst_mask", pending_mask, 32'h0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_mem_ready", mem_ready, 1'b1);
        rst = 1'b0;

        // Single write, contention twice (after a fresh reset), x0 discard.
        vt[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        32'h20, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 32'h20, 1'b1, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hDEADBEEF, 32'h0,  1'b1, 1'b1};
        vt[3]  = '{1'b1, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0,        32'h6,  1'b1, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd1, 32'h11,       32'h6,  1'b1, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b1, 5'd2, 32'h22,       32'h1C, 1'b1, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33,       32'h18, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'h44,       32'h10, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd4, 32'h44,       32'h0,  1'b1, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd4, 32'h44,       32'h0,  1'b1, 1'b1};
        vt[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd4, 32'h44,       32'h0,  1'b1, 1'b1};

        for (int i = 0; i < 11; i++) begin
            if (vt[i].rst_before) do_reset();
            alu_valid = vt[i].av; alu_dst = vt[i].ad; alu_data = vt[i].aw;
            mem_valid = vt[i].mv; mem_dst = vt[i].md; mem_data = vt[i].mw;
            tick();
            chk($sformatf("vec%0d_we", i), reg_write_enable, vt[i].e_we);
            chk($sformatf("vec%0d_dst", i), dst_reg, vt[i].e_dst);
            chk($sformatf("vec%0d_data", i), dst_reg_data, vt[i].e_data);
            chk($sformatf("vec%0d_mask", i), pending_mask, vt[i].e_mask);
            chk($sformatf("vec%0d_alu_ready", i), alu_ready, vt[i].e_ar);
            chk($sformatf("vec%0d_mem_ready", i), mem_ready, vt[i].e_mr);
        end
        idle_inputs();

        // Backpressure: memory sends regs 6..9 while ALU streams regs 10..17.
        do_reset();
        foreach (wcount[i]) wcount[i] = 0;
        ai = 0; mi = 0; drop_at = -1;
        for (int c = 0; c < 30; c++) begin
            alu_valid = (ai < 8); alu_dst = 5'(10 + ai); alu_data = 32'hA000 + ai;
            mem_valid = (mi < 4); mem_dst = 5'(6 + mi);  mem_data = 32'hB000 + mi;
            tick();
            if (last_a_acc) ai++;
            if (last_m_acc) mi++;
            if (mem_ready === 1'b0 && drop_at < 0) drop_at = mi;
        end
        idle_inputs();
        chk("bp_mem_ready_drop_after", drop_at, 2);
        chk("bp_alu_sent", ai, 8);
        chk("bp_mem_sent", mi, 4);
        for (int r = 6; r < 18; r++) chk($sformatf("bp_write_count_r%0d", r), wcount[r], 1);

        // Reset mid-stream with both sources loaded.
        do_reset();
        a_cur = '{dst: 5'd20, data: $urandom};
        m_cur = '{dst: 5'd24, data: $urandom};
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_dst = a_cur.dst; alu_data = a_cur.data;
            mem_valid = 1'b1; mem_dst = m_cur.dst; mem_data = m_cur.data;
            tick();
            if (last_a_acc) a_cur = '{dst: a_cur.dst + 5'd1, data: $urandom};
            if (last_m_acc) m_cur = '{dst: m_cur.dst + 5'd1, data: $urandom};
        end
        chk("rst_mid_busy_before", (pending_mask != 0) && (reg_write_enable === 1'b1), 1'b1);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_mid_we", reg_write_enable, 1'b0);
        chk("rst_mid_mask", pending_mask, 32'h0);
        chk("rst_mid_alu_ready", alu_ready, 1'b1);
        chk("rst_mid_mem_ready", mem_ready, 1'b1);
        chk("rst_mid_dst", dst_reg, 5'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        alu_valid = 1'b1; alu_dst = 5'd12; alu_data = 32'hC12;
        mem_valid = 1'b1; mem_dst = 5'd13; mem_data = 32'hD13;
        tick();
        idle_inputs();
        tick();
        chk("rst_first_grant_we", reg_write_enable, 1'b1);
        chk("rst_first_grant_dst", dst_reg, 5'd12);
        chk("rst_first_grant_data", dst_reg_data, 32'hC12);
        tick();
        chk("rst_second_grant_dst", dst_reg, 5'd13);
        tick();

        // Random traffic, x0 included, holding offers while not ready.
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && aq.size() >= DEPTH)) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_dst   = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!(mem_valid && mq.size() >= DEPTH)) begin
                mem_valid = ($urandom_range(0, 2) == 0);
                mem_dst   = 5'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        chk("drain_mask_empty", pending_mask, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_writeback_arbiter

// File: doc/writeback_arbiter.md
# writeback_arbiter

- Collects completed results from the single-cycle ALU path and the multi-cycle memory path.
- Buffers each source independently.
- Arbitrates round-robin between the sources.
- Drives the register file's single write port (dst_reg, dst_reg_data, reg_write_enable) from registered outputs.
- Exports a pending-destination mask, which decode uses for hazard stalls.

## Interface
- ARCH_LEN, 32 (constants_pkg), data width.
- REG_FILE_LEN, 32 (constants_pkg), number of architectural registers.
- FIFO_DEPTH, 2, entries per source buffer; power of two, ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU buffer can accept.
- alu_dst  in  $clog2(REG_FILE_LEN)  ALU destination register.
- alu_data  in  ARCH_LEN  ALU result.
- mem_valid  in  1  memory result offered.
- mem_ready  out  1  memory buffer can accept.
- mem_dst  in  $clog2(REG_FILE_LEN)  memory destination register.
- mem_data  in  ARCH_LEN  load result.
- dst_reg  out  $clog2(REG_FILE_LEN)  register file write address.
- dst_reg_data  out  ARCH_LEN  register file write data.
- reg_write_enable  out  1  register file write strobe.
- pending_mask  out  REG_FILE_LEN  bit i set while a write to register i is buffered or on the write port.

## Operation
- **Handshake.** A transfer occurs on an edge where valid && ready. valid must not drop, and dst/data must not change, while ready is low.
- **Ready.**
  - ready = source FIFO count < FIFO_DEPTH, taken from registered count only.
  - A pop in the same cycle does not raise ready, so there is no combinational valid-to-ready or ready-to-ready path.
- **x0.** A transfer with dst == 0 is accepted (ready rules unchanged) but discarded. It occupies no FIFO slot and never asserts reg_write_enable.
- **Arbitration.** Performed each cycle on the FIFO heads.
  - Only one FIFO non-empty: that FIFO wins.
  - Both non-empty: the source not granted last wins.
  - last_grant updates only on an actual grant.
- **Output.** The winning head is popped. Its dst/data load into the output registers with reg_write_enable = 1. With no winner, reg_write_enable loads 0 and dst_reg/dst_reg_data hold their previous values.
- **Ordering.**
  - Within a source, FIFO order is preserved.
  - Across sources, the order is arbitration order only.
  - WAW/RAW safety is upstream's job, using pending_mask.
- **pending_mask.**
  - OR of the one-hot dst over all valid FIFO entries, plus the output register when reg_write_enable = 1.
  - Bit 0 is constant 0.
  - The mask is combinational from registered state only.
- **Simultaneous push and pop on a full FIFO.** Cannot occur, because ready was low. Push and pop on a non-full FIFO: count unchanged, both take effect.

## Timing
- **Reset values (asynchronous assert):**
  - Both FIFOs empty; alu_ready = mem_ready = 1.
  - reg_write_enable = 0, dst_reg = 0, dst_reg_data = 0, pending_mask = 0.
  - last_grant = MEM, so the ALU wins the first contested cycle.
- **Reset mid-operation:** all buffered results are dropped and no write is issued.
- **Latency:**
  - Accepted at edge E0 into an empty, uncontested FIFO: output registers load at E1.
  - reg_write_enable is high between E1 and E2.
  - The register file captures at E2.
- **Throughput:** one write per cycle total. Each source sustains one transfer per cycle only while the other source is idle.
- **pending_mask:** bit set from the edge after acceptance; cleared after the cycle in which reg_write_enable presents that write.

## Structure
- Add to instruction_pkg:
  - wb_entry_t, a packed struct {dst: $clog2(REG_FILE_LEN) bits; data: ARCH_LEN bits}.
  - wb_src_e, an enum {WB_SRC_ALU, WB_SRC_MEM}.
- ARCH_LEN and REG_FILE_LEN come from constants_pkg.
- Sub-module wb_fifo, instantiated twice (one per source):
  - Parameterized on depth.
  - Ports: push, entry in, pop, head out, count, full, empty; also exposes its entries for mask generation.
  - Circular buffer with wrapping read/write pointers.
- Top level: round-robin arbiter, output registers, mask OR-tree.

## Test plan
1. **Single write.** After reset, alu_valid for 1 cycle with dst=5, data=0xDEADBEEF.
   - Expected: reg_write_enable high exactly one cycle, 2 edges later, with dst_reg=5, dst_reg_data=0xDEADBEEF.
   - Expected: pending_mask[5] high for 2 cycles.
2. **Contention.** ALU (dst=1, 0x11) and memory (dst=2, 0x22) accepted on the same edge.
   - Expected: writes appear on consecutive cycles, reg 1 then reg 2.
   - Repeat with ALU (dst=3) and memory (dst=4): expected order is reg 3 then reg 4, since round-robin alternates.
3. **Backpressure.** Memory streams 4 results (dst=6..9) while ALU streams continuously.
   - Expected: mem_ready drops after 2 accepted entries.
   - Expected: no result lost or duplicated; per-source order preserved; writes alternate sources.
4. **x0 discard.** alu_dst=0, data=0xFFFFFFFF accepted.
   - Expected: no reg_write_enable, pending_mask stays 0, alu_ready stays 1.
5. **Reset mid-stream.** Assert rst asynchronously with both FIFOs full.
   - Expected: reg_write_enable=0 and pending_mask=0 immediately, both ready=1.
   - Expected: after release, the first contested grant goes to the ALU.
